// File: rtl/mem_bus_arbiter_if.sv
// Core-side and memory-side signals of the instruction/data bus arbiter.
// master: arbiter view (serves the core ports, drives the memory bus).
// slave:  environment view (core pipeline plus external memory).
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  instrReq__i;
    logic [ADDR_WIDTH-1:0] instrAddr__i;
    logic [DATA_WIDTH-1:0] instrData__o;
    logic                  memRead__i;
    logic                  memWrite__i;
    logic [ADDR_WIDTH-1:0] memAddr__i;
    logic [DATA_WIDTH-1:0] memDataWrite__i;
    logic [DATA_WIDTH-1:0] memDataRead__o;
    logic                  stall__o;
    logic                  busReq__o;
    logic                  busWrite__o;
    logic [ADDR_WIDTH-1:0] busAddr__o;
    logic [DATA_WIDTH-1:0] busDataWrite__o;
    logic                  busAck__i;
    logic [DATA_WIDTH-1:0] busDataRead__i;
    logic                  busError__o;

    modport master (
        input  instrReq__i, instrAddr__i, memRead__i, memWrite__i,
               memAddr__i, memDataWrite__i, busAck__i, busDataRead__i,
        output instrData__o, memDataRead__o, stall__o, busReq__o,
               busWrite__o, busAddr__o, busDataWrite__o, busError__o
    );

    modport slave (
        output instrReq__i, instrAddr__i, memRead__i, memWrite__i,
               memAddr__i, memDataWrite__i, busAck__i, busDataRead__i,
        input  instrData__o, memDataRead__o, stall__o, busReq__o,
               busWrite__o, busAddr__o, busDataWrite__o, busError__o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shared memory bus arbiter for the IF and MEM ports of the 5-stage core.
// Data accesses win over fetches; the pipeline is stalled until every access
// requested for the current pipeline cycle has completed.
// Optional macro BUS_TIMEOUT_EN: aborts a bus transaction after
// TIMEOUT_CYCLES unacknowledged cycles and raises a sticky busError__o.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no bus transaction, picking the next unserved request
// ST_INSTR | fetch transaction on the bus, waiting for busAck__i
// ST_DATA  | load/store transaction on the bus, waiting for busAck__i
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock__i,
    input  logic              reset_n__i,
    mem_bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INSTR = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state_q, state_d;
    logic                  instr_done_q, instr_done_d;
    logic                  mem_done_q, mem_done_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_write_q, bus_write_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_WIDTH-1:0] instr_data_q, instr_data_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic                  mem_req;
    logic                  stall;
    logic                  timeout;
    logic                  xfer_end;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             bus_error_q, bus_error_d;
`endif

    // Next-state, bus latching, result capture and done-flag bookkeeping.
    always_comb begin
        mem_req = bus.memRead__i | bus.memWrite__i;
        stall   = (bus.instrReq__i & ~instr_done_q) | (mem_req & ~mem_done_q);

        state_d      = state_q;
        instr_done_d = instr_done_q;
        mem_done_d   = mem_done_q;
        bus_req_d    = bus_req_q;
        bus_write_d  = bus_write_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        instr_data_d = instr_data_q;
        mem_rdata_d  = mem_rdata_q;

`ifdef BUS_TIMEOUT_EN
        bus_error_d = bus_error_q;
        wait_cnt_d  = (state_q == ST_IDLE) ? '0 : wait_cnt_q + 1'b1;
        // An ack in the last allowed cycle still completes normally.
        timeout     = (state_q != ST_IDLE) && !bus.busAck__i &&
                      (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
        timeout = 1'b0;
`endif
        xfer_end = bus.busAck__i | timeout;

        case (state_q)
            ST_IDLE: begin
                if (mem_req && !mem_done_q) begin
                    state_d     = ST_DATA;
                    bus_req_d   = 1'b1;
                    bus_write_d = bus.memWrite__i;
                    bus_addr_d  = bus.memAddr__i;
                    bus_wdata_d = bus.memDataWrite__i;
                end else if (bus.instrReq__i && !instr_done_q) begin
                    state_d     = ST_INSTR;
                    bus_req_d   = 1'b1;
                    bus_write_d = 1'b0;
                    bus_addr_d  = bus.instrAddr__i;
                end
            end
            ST_DATA: begin
                if (xfer_end) begin
                    if (!bus_write_q) begin
                        mem_rdata_d = bus.busAck__i ? bus.busDataRead__i : '0;
                    end
                    mem_done_d = 1'b1;
                    // Chain straight into the fetch to avoid an idle bubble.
                    if (bus.instrReq__i && !instr_done_q) begin
                        state_d     = ST_INSTR;
                        bus_write_d = 1'b0;
                        bus_addr_d  = bus.instrAddr__i;
`ifdef BUS_TIMEOUT_EN
                        wait_cnt_d  = '0;
`endif
                    end else begin
                        state_d   = ST_IDLE;
                        bus_req_d = 1'b0;
                    end
                end
            end
            ST_INSTR: begin
                if (xfer_end) begin
                    instr_data_d = bus.busAck__i ? bus.busDataRead__i : '0;
                    instr_done_d = 1'b1;
                    state_d      = ST_IDLE;
                    bus_req_d    = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase

`ifdef BUS_TIMEOUT_EN
        bus_error_d = bus_error_q | timeout;
`endif

        // The pipeline advances on this edge; the next cycle starts fresh.
        if (!stall) begin
            instr_done_d = 1'b0;
            mem_done_d   = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            state_q      <= ST_IDLE;
            instr_done_q <= 1'b0;
            mem_done_q   <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_write_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            instr_data_q <= '0;
            mem_rdata_q  <= '0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt_q   <= '0;
            bus_error_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            instr_done_q <= instr_done_d;
            mem_done_q   <= mem_done_d;
            bus_req_q    <= bus_req_d;
            bus_write_q  <= bus_write_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            instr_data_q <= instr_data_d;
            mem_rdata_q  <= mem_rdata_d;
`ifdef BUS_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            bus_error_q  <= bus_error_d;
`endif
        end
    end

    assign bus.stall__o        = stall;
    assign bus.busReq__o       = bus_req_q;
    assign bus.busWrite__o     = bus_write_q;
    assign bus.busAddr__o      = bus_addr_q;
    assign bus.busDataWrite__o = bus_wdata_q;
    assign bus.instrData__o    = instr_data_q;
    assign bus.memDataRead__o  = mem_rdata_q;
`ifdef BUS_TIMEOUT_EN
    assign bus.busError__o     = bus_error_q;
`else
    assign bus.busError__o     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations
// plus a transaction-level model compared against the DUT every cycle.
module tb_mem_bus_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    mem_bus_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock__i(clk),
        .reset_n__i(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    typedef struct {
        int          wait_n;
        logic [31:0] data;
    } resp_t;
    resp_t resp_q[$];
    int    seen = 0;

    initial begin
        bus.busAck__i      = 1'b0;
        bus.busDataRead__i = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            bus.busAck__i      = 1'b0;
            bus.busDataRead__i = 32'hDEAD_BEEF;
            if (rst_n && bus.busReq__o) begin
                if (resp_q.size() > 0 && seen == resp_q[0].wait_n) begin
                    bus.busAck__i      = 1'b1;
                    bus.busDataRead__i = resp_q[0].data;
                    void'(resp_q.pop_front());
                    seen = 0;
                end else begin
                    seen++;
                end
            end else begin
                seen = 0;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    typedef struct {
        bit          is_data;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    bit          m_busy = 0;
    bit          m_inst_done = 0;
    bit          m_mem_done = 0;
    bit          m_err = 0;
    int          m_wait = 0;
    txn_t        m_cur;
    logic [31:0] m_instr_data = '0;
    logic [31:0] m_mem_data = '0;

    function automatic txn_t pending_txn(input bit want_data);
        txn_t t;
        t.is_data = want_data;
        t.write   = want_data && bus.memWrite__i;
        t.addr    = want_data ? bus.memAddr__i : bus.instrAddr__i;
        t.wdata   = bus.memDataWrite__i;
        return t;
    endfunction

    task automatic model_step();
        bit need_mem, need_inst, pipe_moves, hit, tmo, from_data;
        need_mem   = (bus.memRead__i || bus.memWrite__i) && !m_mem_done;
        need_inst  = bus.instrReq__i && !m_inst_done;
        pipe_moves = !(need_mem || need_inst);
        if (m_busy) begin
            hit = bus.busAck__i;
            tmo = 0;
`ifdef BUS_TIMEOUT_EN
            tmo = !hit && (m_wait == TMO - 1);
`endif
            if (hit || tmo) begin
                from_data = m_cur.is_data;
                if (from_data) begin
                    if (!m_cur.write) m_mem_data = hit ? bus.busDataRead__i : 32'h0;
                    m_mem_done = 1;
                end else begin
                    m_instr_data = hit ? bus.busDataRead__i : 32'h0;
                    m_inst_done  = 1;
                end
                if (tmo) m_err = 1;
                m_busy = 0;
                if (from_data && need_inst) begin
                    m_cur  = pending_txn(0);
                    m_busy = 1;
                    m_wait = 0;
                end
            end else begin
                m_wait++;
            end
        end else if (need_mem || need_inst) begin
            m_cur  = pending_txn(need_mem);
            m_busy = 1;
            m_wait = 0;
        end
        if (pipe_moves) begin
            m_inst_done = 0;
            m_mem_done  = 0;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy       = 0;
            m_inst_done  = 0;
            m_mem_done   = 0;
            m_err        = 0;
            m_wait       = 0;
            m_instr_data = '0;
            m_mem_data   = '0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        chk("cyc_stall", bus.stall__o,
            ((bus.memRead__i || bus.memWrite__i) && !m_mem_done) ||
            (bus.instrReq__i && !m_inst_done));
        chk("cyc_busreq", bus.busReq__o, m_busy);
        if (m_busy) begin
            chk("cyc_busaddr", bus.busAddr__o, m_cur.addr);
            chk("cyc_buswrite", bus.busWrite__o, m_cur.write);
            if (m_cur.write) chk("cyc_buswdata", bus.busDataWrite__o, m_cur.wdata);
        end
        chk("cyc_instrdata", bus.instrData__o, m_instr_data);
        chk("cyc_memdata", bus.memDataRead__o, m_mem_data);
        chk("cyc_buserror", bus.busError__o, m_err);
    end

    // ---------------- directed scenarios ----------------
    logic [31:0] addr_log[$];
    logic [31:0] wd_log[$];
    bit          wr_log[$];

    task automatic wait_free(output int n_stall, output int n_req);
        n_stall = 0;
        n_req   = 0;
        addr_log.delete();
        wd_log.delete();
        wr_log.delete();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.stall__o) begin
                @(posedge clk);
                #1;
                return;
            end
            n_stall++;
            if (bus.busReq__o) begin
                n_req++;
                addr_log.push_back(bus.busAddr__o);
                wr_log.push_back(bus.busWrite__o);
                wd_log.push_back(bus.busDataWrite__o);
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_free: stall still high after 100 cycles at %0t", $time);
    endtask

    logic [31:0] t3_addr[4] = '{32'h40, 32'h40, 32'h104, 32'h104};
    bit          t3_wr[4]   = '{1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ns, nr;
        bus.instrReq__i     = 1'b0;
        bus.instrAddr__i    = '0;
        bus.memRead__i      = 1'b0;
        bus.memWrite__i     = 1'b0;
        bus.memAddr__i      = '0;
        bus.memDataWrite__i = '0;

        #7;
        chk("rst_busreq", bus.busReq__o, 0);
        chk("rst_stall", bus.stall__o, 0);
        chk("rst_instrdata", bus.instrData__o, 0);
        chk("rst_memdata", bus.memDataRead__o, 0);
        chk("rst_buserror", bus.busError__o, 0);
        chk("rst_busaddr", bus.busAddr__o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // idle
        repeat (10) begin
            @(negedge clk);
            chk("idle_stall", bus.stall__o, 0);
            chk("idle_busreq", bus.busReq__o, 0);
        end
        @(posedge clk);
        #1;

        // single fetch, ack in first bus cycle
        resp_q.push_back('{0, 32'h2010_0004});
        bus.instrReq__i  = 1'b1;
        bus.instrAddr__i = 32'h100;
        wait_free(ns, nr);
        bus.instrReq__i  = 1'b0;
        chk("fetch_stall_cycles", ns, 2);
        chk("fetch_req_cycles", nr, 1);
        if (addr_log.size() > 0) chk("fetch_busaddr", addr_log[0], 32'h100);
        chk("fetch_instrdata", bus.instrData__o, 32'h2010_0004);

        // load with three wait cycles
        resp_q.push_back('{3, 32'h1234_5678});
        bus.memRead__i = 1'b1;
        bus.memAddr__i = 32'h80;
        wait_free(ns, nr);
        bus.memRead__i = 1'b0;
        chk("load_stall_cycles", ns, 5);
        chk("load_req_cycles", nr, 4);
        foreach (addr_log[i]) begin
            chk("load_busaddr", addr_log[i], 32'h80);
            chk("load_buswrite", wr_log[i], 0);
        end
        chk("load_memdata", bus.memDataRead__o, 32'h1234_5678);

        // store plus fetch, data first then fetch back-to-back
        resp_q.push_back('{1, 32'h5555_5555});
        resp_q.push_back('{1, 32'h8C01_0000});
        bus.memWrite__i     = 1'b1;
        bus.memAddr__i      = 32'h40;
        bus.memDataWrite__i = 32'hCAFE_F00D;
        bus.instrReq__i     = 1'b1;
        bus.instrAddr__i    = 32'h104;
        wait_free(ns, nr);
        bus.memWrite__i     = 1'b0;
        bus.instrReq__i     = 1'b0;
        chk("st_if_stall_cycles", ns, 5);
        chk("st_if_req_cycles", nr, 4);
        foreach (addr_log[i]) begin
            if (i < 4) begin
                chk("st_if_busaddr", addr_log[i], t3_addr[i]);
                chk("st_if_buswrite", wr_log[i], t3_wr[i]);
                if (t3_wr[i]) chk("st_if_buswdata", wd_log[i], 32'hCAFE_F00D);
            end
        end
        chk("st_if_memdata_kept", bus.memDataRead__o, 32'h1234_5678);
        chk("st_if_instrdata", bus.instrData__o, 32'h8C01_0000);

        // read and write together act as a write
        resp_q.push_back('{0, 32'h6666_6666});
        bus.memRead__i      = 1'b1;
        bus.memWrite__i     = 1'b1;
        bus.memAddr__i      = 32'h44;
        bus.memDataWrite__i = 32'h0BAD_CAFE;
        wait_free(ns, nr);
        bus.memRead__i      = 1'b0;
        bus.memWrite__i     = 1'b0;
        chk("rw_stall_cycles", ns, 2);
        if (wr_log.size() > 0) chk("rw_buswrite", wr_log[0], 1);
        if (wd_log.size() > 0) chk("rw_buswdata", wd_log[0], 32'h0BAD_CAFE);
        chk("rw_memdata_kept", bus.memDataRead__o, 32'h1234_5678);

        // reset in the middle of a data wait, then the request restarts
        resp_q.push_back('{5, 32'hA5A5_0001});
        bus.memRead__i = 1'b1;
        bus.memAddr__i = 32'h90;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_mid_busreq_before", bus.busReq__o, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busreq", bus.busReq__o, 0);
        chk("rst_mid_memdata", bus.memDataRead__o, 0);
        chk("rst_mid_instrdata", bus.instrData__o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_free(ns, nr);
        bus.memRead__i = 1'b0;
        chk("rst_restart_stall_cycles", ns, 7);
        chk("rst_restart_req_cycles", nr, 6);
        chk("rst_restart_memdata", bus.memDataRead__o, 32'hA5A5_0001);

`ifdef BUS_TIMEOUT_EN
        // no ack: abort after TMO bus cycles
        bus.memRead__i = 1'b1;
        bus.memAddr__i = 32'hC0;
        wait_free(ns, nr);
        bus.memRead__i = 1'b0;
        chk("tmo_req_cycles", nr, 8);
        chk("tmo_stall_cycles", ns, 9);
        chk("tmo_memdata", bus.memDataRead__o, 0);
        chk("tmo_buserror", bus.busError__o, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("tmo_buserror_sticky", bus.busError__o, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // ack on the last allowed cycle wins
        resp_q.push_back('{7, 32'h7777_0007});
        bus.memRead__i = 1'b1;
        bus.memAddr__i = 32'hC4;
        wait_free(ns, nr);
        bus.memRead__i = 1'b0;
        chk("late_ack_req_cycles", nr, 8);
        chk("late_ack_stall_cycles", ns, 9);
        chk("late_ack_memdata", bus.memDataRead__o, 32'h7777_0007);
        chk("late_ack_buserror", bus.busError__o, 0);
`else
        chk("no_tmo_buserror", bus.busError__o, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Arbitrates one shared, variable-latency memory bus between the instruction-fetch port (IF stage) and the data-access port (MEM stage) of the 5-stage MIPS core. It serialises requests, gives data accesses priority over fetches, and holds returned data in registers. It raises a single global pipeline stall until every pending access for the current pipeline cycle has completed. It sits between the core's instruction/data memory ports and the external memory.

Parameters:
ADDR_WIDTH, 32, bus and port address width
DATA_WIDTH, 32, bus and port data width
TIMEOUT_CYCLES, 255, max wait cycles per bus transaction (used only with the optional feature)

Ports:
clock__i  input  1  core clock, all state rising-edge
reset_n__i  input  1  asynchronous active-low reset
instrReq__i  input  1  IF stage wants an instruction this pipeline cycle
instrAddr__i  input  ADDR_WIDTH  fetch address (PC)
instrData__o  output  DATA_WIDTH  registered fetched instruction
memRead__i  input  1  MEM stage load
memWrite__i  input  1  MEM stage store
memAddr__i  input  ADDR_WIDTH  data address
memDataWrite__i  input  DATA_WIDTH  store data
memDataRead__o  output  DATA_WIDTH  registered load data
stall__o  output  1  global pipeline stall (freezes PC and all pipeline registers)
busReq__o  output  1  bus transaction request
busWrite__o  output  1  1 = write, 0 = read
busAddr__o  output  ADDR_WIDTH  latched transaction address
busDataWrite__o  output  DATA_WIDTH  latched write data
busAck__i  input  1  single-cycle completion strobe from memory
busDataRead__i  input  DATA_WIDTH  read data, valid with busAck__i
busError__o  output  1  sticky timeout flag (0 when feature compiled out)

Behaviour:
- memReq = memRead__i | memWrite__i. If both are high, the access is a write.
- FSM states are IDLE, INSTR, DATA. Done flags are instrDone and memDone.
- stall__o is combinational: (instrReq__i & ~instrDone) | (memReq & ~memDone).
- On any rising edge with stall__o = 0, both done flags clear. Clearing takes priority over setting.
- IDLE: if memReq & ~memDone, latch memAddr/memDataWrite/write and go to DATA. Else if instrReq__i & ~instrDone, latch instrAddr, write = 0, and go to INSTR. Otherwise stay in IDLE.
- INSTR/DATA: busReq__o = 1. busAddr/busWrite/busDataWrite stay stable until the ack.
- On busAck__i in DATA:
  - memDataRead__o <= busDataRead__i (reads only; stores leave it unchanged) and memDone <= 1.
  - If instrReq__i & ~instrDone, go directly to INSTR (no IDLE bubble), latching instrAddr. Otherwise go to IDLE.
- On busAck__i in INSTR: instrData__o <= busDataRead__i, instrDone <= 1, go to IDLE.
- busAck__i in IDLE is ignored.
- Latency: request seen in IDLE at cycle 0, busReq at cycle 1, ack at cycle 1+W (W ≥ 0 wait cycles), stall__o low at cycle 2+W.
- Requests that drop while a transaction is in flight do not abort it. The pipeline holds inputs stable while stalled.
- Data port priority is fixed. No starvation is possible, because the whole pipeline stalls until both flags are satisfied.
- Reset (asynchronous, any state): state = IDLE, done flags = 0, busReq__o/busWrite__o = 0, busAddr/busDataWrite/instrData__o/memDataRead__o = 0, busError__o = 0. busReq__o drops immediately, not at the next edge.

Optional Feature:
BUS_TIMEOUT_EN
- Defined:
  - A wait counter clears on entering INSTR/DATA and increments each cycle busReq__o = 1 without an ack.
  - When the counter reaches TIMEOUT_CYCLES, the transaction aborts: busReq__o drops, the port's data register loads 0, its done flag sets, and the FSM takes the normal post-ack transition.
  - busError__o sets to 1 and stays 1 until reset.
  - If an ack and the timeout occur in the same cycle, the ack wins and no error is flagged.
- Not defined: no counter logic; busError__o is tied to 0 and the block waits indefinitely.

Test Plan:
1. No requests for 10 cycles -> stall__o = 0, busReq__o = 0, FSM in IDLE throughout.
2. instrReq, addr 0x0000_0100, ack in the first busReq cycle with data 0x2010_0004 -> stall__o high exactly 2 cycles, busAddr = 0x100, instrData__o = 0x2010_0004 when stall drops.
3. memWrite addr 0x40 data 0xCAFE_F00D plus instrReq addr 0x104, each ack after 1 wait cycle -> DATA first (busWrite = 1, busDataWrite = 0xCAFE_F00D), INSTR back-to-back with busAddr = 0x104, stall__o low the cycle after the second ack, memDataRead__o unchanged.
4. memRead addr 0x80, ack after 3 wait cycles with 0x1234_5678 -> busReq held 4 cycles with stable address, memDataRead__o = 0x1234_5678, stall__o high 5 cycles.
5. reset_n__i asserted mid-wait in DATA -> busReq__o = 0 immediately. After release, the same request restarts from IDLE and completes normally.
6. With BUS_TIMEOUT_EN and TIMEOUT_CYCLES = 8, memRead with no ack -> busReq high 8 cycles then low, memDataRead__o = 0, busError__o = 1 sticky, stall__o released. Repeat with the ack arriving on the 8th cycle -> no error.
